// File: rtl/pad_mux_pkg.sv
// Shared types and helpers for the runtime pad multiplexer.
//   cfg_type_e      : which select table a configuration request targets
//   seq_state_e     : break-before-make sequencer states
//   idx_width/sel_width : width helpers for the configuration index/select
//   SunburstPadMap  : default board map, written by software after reset
package pad_mux_pkg;

    typedef enum logic {
        CfgOut = 1'b0,   // pad output select
        CfgIn  = 1'b1    // peripheral input select
    } cfg_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StQuiesce,
        StSwitch,
        StSettle,
        StDone
    } seq_state_e;

    function automatic int idx_width(input int n_pads, input int n_in);
        return $clog2(n_pads > n_in ? n_pads : n_in);
    endfunction

    // Select value 0 means "none", so the encoding needs one extra code.
    function automatic int sel_width(input int n_pads, input int n_out);
        return $clog2((n_pads > n_out ? n_pads : n_out) + 1);
    endfunction

    typedef struct packed {
        cfg_type_e   typ;
        logic [7:0]  idx;
        logic [7:0]  sel;
    } pad_map_t;

    // Sunburst bring-up map; each entry is replayed as one cfg request.
    localparam int SunburstMapLen = 4;
    localparam pad_map_t SunburstPadMap [SunburstMapLen] = '{
        '{CfgOut, 8'd0, 8'd1},
        '{CfgIn,  8'd0, 8'd2},
        '{CfgOut, 8'd2, 8'd3},
        '{CfgOut, 8'd3, 8'd4}
    };

endpackage

// File: rtl/pad_mux_ctrl_if.sv
// Configuration handshake between software-facing logic and pad_mux_ctrl.
//   cfg_req/cfg_type/cfg_idx/cfg_sel : request, held until cfg_ack
//   cfg_ack/cfg_err                  : one-cycle completion pulse + reject flag
//   busy                             : sequencer not idle
interface pad_mux_ctrl_if
    import pad_mux_pkg::*;
#(
    parameter int IdxW = 7,
    parameter int SelW = 7
) ();
    logic            cfg_req;
    cfg_type_e       cfg_type;
    logic [IdxW-1:0] cfg_idx;
    logic [SelW-1:0] cfg_sel;
    logic            cfg_ack;
    logic            cfg_err;
    logic            busy;

    modport master (output cfg_req, cfg_type, cfg_idx, cfg_sel,
                    input  cfg_ack, cfg_err, busy);
    modport slave  (input  cfg_req, cfg_type, cfg_idx, cfg_sel,
                    output cfg_ack, cfg_err, busy);
endinterface

// File: rtl/pad_mux_seq.sv
// Break-before-make sequencer: validates a request, quiesces the target
// (pad oe forced low or peripheral input frozen) for GuardCycles, writes the
// select in SWITCH, settles one cycle, then pulses ack.
//   req/type/idx/sel in  : captured in IDLE only
//   force_*/freeze_*     : quiesce controls for the datapath
//   wr_*                 : one-cycle select-table write strobe
//   ack/err/busy         : completion status
module pad_mux_seq
    import pad_mux_pkg::*;
#(
    parameter int NPads       = 68,
    parameter int NPeriphOut  = 64,
    parameter int NPeriphIn   = 32,
    parameter int GuardCycles = 4,
    parameter int IdxW        = 7,
    parameter int SelW        = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_i,
    input  cfg_type_e       type_i,
    input  logic [IdxW-1:0] idx_i,
    input  logic [SelW-1:0] sel_i,
    output logic            force_en_o,
    output logic [IdxW-1:0] force_pad_idx_o,
    output logic            freeze_en_o,
    output logic [IdxW-1:0] freeze_idx_o,
    output logic            wr_en_o,
    output cfg_type_e       wr_type_o,
    output logic [IdxW-1:0] wr_idx_o,
    output logic [SelW-1:0] wr_sel_o,
    output logic            ack_o,
    output logic            err_o,
    output logic            busy_o
);
    localparam int CntW = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;

    seq_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    cfg_type_e       type_q;
    logic [IdxW-1:0] idx_q;
    logic [SelW-1:0] sel_q;
    logic            err_q, ack_q, force_q, freeze_q;
    logic            req_ok;

    always_comb begin
        req_ok = 1'b0;
        if (type_i == CfgOut) req_ok = (32'(idx_i) < 32'(NPads))     && (32'(sel_i) <= 32'(NPeriphOut));
        else                  req_ok = (32'(idx_i) < 32'(NPeriphIn)) && (32'(sel_i) <= 32'(NPads));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            type_q   <= CfgOut;
            idx_q    <= '0;
            sel_q    <= '0;
            err_q    <= 1'b0;
            ack_q    <= 1'b0;
            force_q  <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StIdle: if (req_i) begin
                    type_q <= type_i;
                    idx_q  <= idx_i;
                    sel_q  <= sel_i;
                    if (req_ok) begin
                        state_q  <= StQuiesce;
                        cnt_q    <= CntW'(GuardCycles - 1);
                        force_q  <= (type_i == CfgOut);
                        freeze_q <= (type_i == CfgIn);
                    end else begin
                        state_q <= StDone;
                        err_q   <= 1'b1;
                        ack_q   <= 1'b1;
                    end
                end
                StQuiesce: begin
                    if (cnt_q == '0) state_q <= StSwitch;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                StSwitch: state_q <= StSettle;
                StSettle: begin
                    state_q  <= StDone;
                    force_q  <= 1'b0;
                    freeze_q <= 1'b0;
                    ack_q    <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                    err_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign force_en_o      = force_q;
    assign force_pad_idx_o = idx_q;
    assign freeze_en_o     = freeze_q;
    assign freeze_idx_o    = idx_q;
    assign wr_en_o         = (state_q == StSwitch);
    assign wr_type_o       = type_q;
    assign wr_idx_o        = idx_q;
    assign wr_sel_o        = sel_q;
    assign ack_o           = ack_q;
    assign err_o           = err_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: rtl/pad_mux_ctrl.sv
// Runtime pin multiplexer between peripheral cio_* signals and the padring.
//   periph_out_i/periph_oe_i : peripheral output values / enables
//   periph_in_o              : inputs delivered to peripherals
//   pad_out_o/pad_oe_o/pad_in_i : padring vectors
//   cfg                      : configuration handshake (slave side)
module pad_mux_ctrl
    import pad_mux_pkg::*;
#(
    parameter int                   NPads       = 68,
    parameter int                   NPeriphOut  = 64,
    parameter int                   NPeriphIn   = 32,
    parameter int                   GuardCycles = 4,
    parameter logic [NPeriphIn-1:0] InDefault   = '1,
    localparam int                  IdxW        = idx_width(NPads, NPeriphIn),
    localparam int                  SelW        = sel_width(NPads, NPeriphOut)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NPeriphOut-1:0] periph_out_i,
    input  logic [NPeriphOut-1:0] periph_oe_i,
    output logic [NPeriphIn-1:0]  periph_in_o,
    output logic [NPads-1:0]      pad_out_o,
    output logic [NPads-1:0]      pad_oe_o,
    input  logic [NPads-1:0]      pad_in_i,
    pad_mux_ctrl_if.slave         cfg
);
    logic [NPads-1:0][SelW-1:0]     outsel_q, outsel_d;
    logic [NPeriphIn-1:0][SelW-1:0] insel_q, insel_d;
    logic [NPeriphIn-1:0]           in_hold_q, in_hold_d;

    logic            force_en, freeze_en, wr_en;
    logic [IdxW-1:0] force_idx, freeze_idx, wr_idx;
    logic [SelW-1:0] wr_sel;
    cfg_type_e       wr_type;

    pad_mux_seq #(
        .NPads(NPads), .NPeriphOut(NPeriphOut), .NPeriphIn(NPeriphIn),
        .GuardCycles(GuardCycles), .IdxW(IdxW), .SelW(SelW)
    ) u_seq (
        .clk_i, .rst_ni,
        .req_i(cfg.cfg_req), .type_i(cfg.cfg_type), .idx_i(cfg.cfg_idx), .sel_i(cfg.cfg_sel),
        .force_en_o(force_en), .force_pad_idx_o(force_idx),
        .freeze_en_o(freeze_en), .freeze_idx_o(freeze_idx),
        .wr_en_o(wr_en), .wr_type_o(wr_type), .wr_idx_o(wr_idx), .wr_sel_o(wr_sel),
        .ack_o(cfg.cfg_ack), .err_o(cfg.cfg_err), .busy_o(cfg.busy)
    );

    always_comb begin
        outsel_d = outsel_q;
        insel_d  = insel_q;
        if (wr_en) begin
            for (int p = 0; p < NPads; p++)
                if (wr_type == CfgOut && wr_idx == IdxW'(p)) outsel_d[p] = wr_sel;
            for (int i = 0; i < NPeriphIn; i++)
                if (wr_type == CfgIn && wr_idx == IdxW'(i)) insel_d[i] = wr_sel;
        end
    end

    // Sources shifted up by one so select 0 lands on a constant 0 and the
    // select value indexes directly; padded to the full select range.
    logic [2**SelW-1:0] out_ext, oe_ext, in_ext;
    always_comb begin
        out_ext = '0;
        oe_ext  = '0;
        in_ext  = '0;
        out_ext[NPeriphOut:0] = {periph_out_i, 1'b0};
        oe_ext[NPeriphOut:0]  = {periph_oe_i, 1'b0};
        in_ext[NPads:0]       = {pad_in_i, 1'b0};
    end

    always_comb begin
        pad_out_o   = '0;
        pad_oe_o    = '0;
        periph_in_o = '0;
        for (int p = 0; p < NPads; p++) begin
            pad_out_o[p] = out_ext[outsel_q[p]];
            pad_oe_o[p]  = oe_ext[outsel_q[p]] & ~(force_en && force_idx == IdxW'(p));
        end
        for (int i = 0; i < NPeriphIn; i++) begin
            if (freeze_en && freeze_idx == IdxW'(i)) periph_in_o[i] = in_hold_q[i];
            else if (insel_q[i] != '0)               periph_in_o[i] = in_ext[insel_q[i]];
            else                                     periph_in_o[i] = InDefault[i];
        end
        // Tracks the delivered value every cycle, so at freeze entry it
        // holds the last value the peripheral saw.
        in_hold_d = periph_in_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outsel_q  <= '0;
            insel_q   <= '0;
            in_hold_q <= InDefault;
        end else begin
            outsel_q  <= outsel_d;
            insel_q   <= insel_d;
            in_hold_q <= in_hold_d;
        end
    end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
module tb_pad_mux_ctrl;
    import pad_mux_pkg::*;

    localparam int NP = 68, NO = 64, NI = 32, G = 4, IW = 7, SW = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NO-1:0] periph_out, periph_oe;
    logic [NI-1:0] periph_in;
    logic [NP-1:0] pad_out, pad_oe, pad_in;

    pad_mux_ctrl_if #(.IdxW(IW), .SelW(SW)) cfg ();

    pad_mux_ctrl #(.NPads(NP), .NPeriphOut(NO), .NPeriphIn(NI), .GuardCycles(G)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .periph_out_i(periph_out), .periph_oe_i(periph_oe), .periph_in_o(periph_in),
        .pad_out_o(pad_out), .pad_oe_o(pad_oe), .pad_in_i(pad_in),
        .cfg(cfg)
    );

    int n_cmp = 0, n_bad = 0;

    // reference: select tables plus the quiesce target currently in effect
    int   m_outsel [NP];
    int   m_insel  [NI];
    bit   frc_en, frz_en;
    int   frc_idx, frz_idx;
    logic frz_val;
    bit   pin4, tog60;
    int   oe60_low;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic live_in(input int i);
        return (m_insel[i] != 0) ? pad_in[m_insel[i]-1] : 1'b1;
    endfunction

    task automatic drive_rand();
        logic last60;
        last60     = pad_in[60];
        periph_out = {$urandom, $urandom};
        periph_oe  = {$urandom, $urandom};
        pad_in     = {4'($urandom), $urandom, $urandom};
        if (pin4)  periph_oe[4] = 1'b1;
        if (tog60) pad_in[60] = ~last60;
    endtask

    task automatic check_all(input logic ack, input logic err, input logic busy);
        logic [NP-1:0] eo, ee;
        logic [NI-1:0] ei;
        for (int p = 0; p < NP; p++) begin
            eo[p] = (m_outsel[p] != 0) ? periph_out[m_outsel[p]-1] : 1'b0;
            ee[p] = (m_outsel[p] != 0) ? periph_oe[m_outsel[p]-1] : 1'b0;
            if (frc_en && frc_idx == p) ee[p] = 1'b0;
        end
        for (int i = 0; i < NI; i++)
            ei[i] = (frz_en && frz_idx == i) ? frz_val : live_in(i);
        if (pad_oe[60] === 1'b0) oe60_low++;
        chk("pad_out",   128'(pad_out),   128'(eo));
        chk("pad_oe",    128'(pad_oe),    128'(ee));
        chk("periph_in", 128'(periph_in), 128'(ei));
        chk("ack",       128'(cfg.cfg_ack), 128'(ack));
        chk("err",       128'(cfg.cfg_err), 128'(err));
        chk("busy",      128'(cfg.busy),    128'(busy));
    endtask

    // Called at a negedge with the DUT idle; the request is sampled at the
    // next posedge. Ends at the negedge of the idle cycle after ack.
    task automatic run_cfg(input bit typ, input int idx, input int sel,
                           input bit nreq, input bit ntyp, input int nidx, input int nsel);
        bit valid;
        int lat;
        valid = (typ == 1'b0) ? (idx < NP && sel <= NO) : (idx < NI && sel <= NP);
        lat   = valid ? G + 3 : 1;
        cfg.cfg_req  = 1'b1;
        cfg.cfg_type = cfg_type_e'(typ);
        cfg.cfg_idx  = IW'(idx);
        cfg.cfg_sel  = SW'(sel);
        if (valid && typ) frz_val = live_in(idx);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            drive_rand();
            // fields are don't-care once captured; req stays high to ack
            if (k < lat) begin
                cfg.cfg_type = cfg_type_e'($urandom_range(0, 1));
                cfg.cfg_idx  = IW'($urandom);
                cfg.cfg_sel  = SW'($urandom);
            end
            @(negedge clk);
            if (valid && k <= G + 2) begin
                if (typ) begin frz_en = 1'b1; frz_idx = idx; end
                else     begin frc_en = 1'b1; frc_idx = idx; end
            end
            if (valid && k == G + 2) begin
                if (typ) m_insel[idx] = sel;
                else     m_outsel[idx] = sel;
            end
            if (k == lat) begin frc_en = 1'b0; frz_en = 1'b0; end
            check_all(k == lat, (k == lat) && !valid, 1'b1);
        end
        @(posedge clk); #1;
        drive_rand();
        cfg.cfg_req = nreq;
        if (nreq) begin
            cfg.cfg_type = cfg_type_e'(ntyp);
            cfg.cfg_idx  = IW'(nidx);
            cfg.cfg_sel  = SW'(nsel);
        end
        @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0);
    endtask

    task automatic gen_req(output bit t, output int i, output int s);
        bool_bad: begin
            bit bad;
            t   = 1'($urandom_range(0, 1));
            bad = ($urandom_range(0, 7) == 0);
            if (!t) begin
                i = bad && $urandom_range(0, 1) ? $urandom_range(NP, 127) : $urandom_range(0, NP - 1);
                s = bad ? $urandom_range(NO + 1, 127) : $urandom_range(0, NO);
            end else begin
                i = bad && $urandom_range(0, 1) ? $urandom_range(NI, 127) : $urandom_range(0, NI - 1);
                s = bad ? $urandom_range(NP + 1, 127) : $urandom_range(0, NP);
            end
        end
    endtask

    initial begin
        bit t, nt, pend;
        int i, s, ni, ns;
        for (int p = 0; p < NP; p++) m_outsel[p] = 0;
        for (int q = 0; q < NI; q++) m_insel[q] = 0;
        frc_en = 0; frz_en = 0; frc_idx = 0; frz_idx = 0; frz_val = 1'b1;
        pin4 = 0; tog60 = 0; oe60_low = 0;
        rst_n = 1'b0;
        cfg.cfg_req = 1'b0; cfg.cfg_type = CfgOut; cfg.cfg_idx = '0; cfg.cfg_sel = '0;
        periph_out = '1; periph_oe = '1; pad_in = '0;

        // reset state with every peripheral enabling its output
        repeat (2) @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1; drive_rand(); @(negedge clk);
        check_all(1'b0, 1'b0, 1'b0);

        // output map, then the same selection again: oe low for the full quiesce
        pin4 = 1;
        run_cfg(0, 60, 5, 0, 0, 0, 0);
        oe60_low = 0;
        run_cfg(0, 60, 5, 0, 0, 0, 0);
        chk("oe60_low_cycles", 128'(oe60_low), 128'(G + 2));
        pin4 = 0;

        // input 3 onto a pad toggling every cycle
        tog60 = 1;
        run_cfg(1, 3, 61, 0, 0, 0, 0);
        run_cfg(0, 7, 0, 0, 0, 0, 0);
        tog60 = 0;

        // rejected requests
        run_cfg(0, 68, 1, 0, 0, 0, 0);
        run_cfg(1, 32, 1, 0, 0, 0, 0);
        run_cfg(0, 0, NO + 1, 0, 0, 0, 0);
        run_cfg(1, 0, NP + 1, 0, 0, 0, 0);
        // fan-out and shared input pad
        run_cfg(0, 61, 5, 0, 0, 0, 0);
        run_cfg(1, 4, 61, 0, 0, 0, 0);

        // reset during QUIESCE
        cfg.cfg_req = 1'b1; cfg.cfg_type = CfgOut; cfg.cfg_idx = IW'(60); cfg.cfg_sel = SW'(9);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1; drive_rand(); @(negedge clk);
            frc_en = 1'b1; frc_idx = 60;
            check_all(1'b0, 1'b0, 1'b1);
        end
        rst_n = 1'b0;
        cfg.cfg_req = 1'b0;
        #1;
        for (int p = 0; p < NP; p++) m_outsel[p] = 0;
        for (int q = 0; q < NI; q++) m_insel[q] = 0;
        frc_en = 1'b0;
        chk("rst_pad_oe", 128'(pad_oe), 128'(0));
        check_all(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; drive_rand(); @(negedge clk);
            check_all(1'b0, 1'b0, 1'b0);
        end
        run_cfg(0, 60, 5, 0, 0, 0, 0);

        // back-to-back: second request accepted the cycle after ack
        run_cfg(0, 10, 7, 1, 1, 5, 20);
        run_cfg(1, 5, 20, 0, 0, 0, 0);

        // randomized traffic, sometimes chained
        pend = 0; nt = 0; ni = 0; ns = 0;
        for (int n = 0; n < 40; n++) begin
            bit chain;
            if (pend) begin t = nt; i = ni; s = ns; end
            else gen_req(t, i, s);
            chain = 1'($urandom_range(0, 1));
            if (chain) gen_req(nt, ni, ns);
            run_cfg(t, i, s, chain, nt, ni, ns);
            pend = chain;
        end
        if (pend) run_cfg(nt, ni, ns, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
